// File: rtl/attractor_classifier.sv
// Attractor classifier: watches one trajectory of network states and reports the first
// revisited state as the attractor entry, along with its period and transient length.
module attractor_classifier #(
    parameter int unsigned STATE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               x_valid,
    input  logic [STATE_W-1:0] x,
    output logic               busy,
    output logic               done,
    output logic               is_fixed,
    output logic [STATE_W:0]   cycle_len,
    output logic [STATE_W:0]   transient_len,
    output logic [STATE_W-1:0] entry_state
);

    localparam int unsigned NumStates = 1 << STATE_W;

    typedef enum logic [1:0] {
        StIdle,
        StTrack,
        StDone
    } state_e;

    state_e state_q, state_d;

    // One flag per possible state, plus the step number at which it was first seen.
    logic [NumStates-1:0] visited_q;
    logic [STATE_W:0]     idx_q [NumStates];
    logic [STATE_W:0]     step_q;

    logic             accept_start;
    logic             sample;
    logic             revisit;
    logic [STATE_W:0] idx_hit;
    logic [STATE_W:0] period;

    // Decode the current sample against the visited map.
    always_comb begin
        accept_start = (state_q == StIdle) && start;
        sample       = (state_q == StTrack) && x_valid;
        revisit      = sample && visited_q[x];
        idx_hit      = idx_q[x];
        period       = step_q - idx_hit;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status outputs, decoded from the state register only.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StTrack;
                end
            end
            StTrack: begin
                busy = 1'b1;
                if (revisit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Visited map, step counter and result registers.
    always_ff @(posedge clk) begin
        if (rst || accept_start) begin
            visited_q     <= '0;
            step_q        <= '0;
            is_fixed      <= 1'b0;
            cycle_len     <= '0;
            transient_len <= '0;
            entry_state   <= '0;
        end else if (revisit) begin
            cycle_len     <= period;
            transient_len <= idx_hit;
            entry_state   <= x;
            is_fixed      <= (period == (STATE_W + 1)'(1));
        end else if (sample) begin
            visited_q[x] <= 1'b1;
            step_q       <= step_q + 1'b1;
        end
    end

    // Step-number table; entries are only read behind a set visited bit, so no reset needed.
    always_ff @(posedge clk) begin
        if (sample && !visited_q[x]) begin
            idx_q[x] <= step_q;
        end
    end

endmodule

// File: tb/tb_attractor_classifier.sv
// Self-checking bench for attractor_classifier: trajectories are fed with optional bubbles
// and stray start pulses, and results are compared against a first-revisit search model.
module tb_attractor_classifier;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       x_valid;
    logic [7:0] x;
    logic       busy;
    logic       done;
    logic       is_fixed;
    logic [8:0] cycle_len;
    logic [8:0] transient_len;
    logic [7:0] entry_state;

    attractor_classifier #(.STATE_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x_valid      (x_valid),
        .x            (x),
        .busy         (busy),
        .done         (done),
        .is_fixed     (is_fixed),
        .cycle_len    (cycle_len),
        .transient_len(transient_len),
        .entry_state  (entry_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // {done, busy, is_fixed, cycle_len, transient_len, entry_state}
    logic [28:0] obs;
    assign obs = {done, busy, is_fixed, cycle_len, transient_len, entry_state};

    logic [7:0] traj[$];
    logic [8:0] exp_cyc;
    logic [8:0] exp_tr;
    logic [7:0] exp_entry;
    logic       exp_fixed;

    // Find the first sample that repeats an earlier one; trim the trajectory there.
    task automatic model();
        int first[256];
        foreach (first[k]) first[k] = -1;
        for (int i = 0; i < traj.size(); i++) begin
            if (first[traj[i]] >= 0) begin
                exp_cyc   = 9'(i - first[traj[i]]);
                exp_tr    = 9'(first[traj[i]]);
                exp_entry = traj[i];
                exp_fixed = (i - first[traj[i]]) == 1;
                while (traj.size() > i + 1) void'(traj.pop_back());
                break;
            end
            first[traj[i]] = i;
        end
    endtask

    // Run one trajectory from start to the cycle after done and check everything on the way.
    task automatic run_traj(input string name, input int max_bubble, input bit noisy);
        int pulses = 0;
        int last;
        logic [28:0] exp_res;
        model();
        last = traj.size() - 1;
        exp_res = {1'b0, 1'b0, exp_fixed, exp_cyc, exp_tr, exp_entry};
        @(negedge clk);
        start = 1'b1; x_valid = 1'b1; x = 8'($urandom);
        @(negedge clk);
        start = 1'b0; x_valid = 1'b0;
        vectors++;
        if (obs !== 29'({1'b0, 1'b1, 27'd0})) begin
            errors++;
            $display("FAIL %s start: obs=%h required=%h", name, obs, 29'({1'b0, 1'b1, 27'd0}));
        end
        for (int i = 0; i <= last; i++) begin
            int nb = (max_bubble > 0) ? $urandom_range(0, max_bubble) : 0;
            for (int b = 0; b < nb; b++) begin
                x_valid = 1'b0; x = 8'($urandom);
                start = noisy ? 1'($urandom) : 1'b0;
                @(negedge clk);
                if (done) pulses++;
            end
            x_valid = 1'b1; x = traj[i];
            start = noisy && (i == last || $urandom_range(0, 3) == 0);
            @(negedge clk);
            if (i != last && done) pulses++;
        end
        x_valid = 1'b0; start = noisy;
        vectors++;
        if (obs !== (exp_res | 29'h1000_0000)) begin
            errors++;
            $display("FAIL %s result: obs=%h required=%h", name, obs, exp_res | 29'h1000_0000);
        end
        vectors++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL %s early_done: got %0d pulses required 0", name, pulses);
        end
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (obs !== exp_res) begin
            errors++;
            $display("FAIL %s hold: obs=%h required=%h", name, obs, exp_res);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; x_valid = 1'b1; x = 8'h5A;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs !== 29'd0) begin
            errors++;
            $display("FAIL reset: obs=%h required=%h", obs, 29'd0);
        end
        rst = 1'b0; start = 1'b0; x_valid = 1'b0;
    endtask

    task automatic test_fixed_point();
        traj = '{8'h00, 8'h00};
        run_traj("fixed_point", 0, 1'b0);
    endtask

    task automatic test_two_cycle();
        traj = '{8'h38, 8'h1C, 8'h38};
        run_traj("two_cycle", 0, 1'b0);
    endtask

    task automatic test_transient();
        traj = '{8'h63, 8'h10, 8'h53, 8'h53};
        run_traj("transient", 0, 1'b0);
    endtask

    task automatic test_bubbles();
        traj = '{8'h63, 8'h10, 8'h53, 8'h53};
        run_traj("bubbles", 3, 1'b1);
    endtask

    task automatic test_worst_case();
        traj = {};
        for (int v = 0; v < 256; v++) traj.push_back(8'(v));
        traj.push_back(8'h00);
        run_traj("worst_full", 0, 1'b0);
        traj = {};
        for (int v = 0; v < 255; v++) traj.push_back(8'(v));
        traj.push_back(8'hFE);
        run_traj("worst_tail", 1, 1'b0);
    endtask

    task automatic test_reset_mid_track();
        logic [7:0] pre[5] = '{8'h01, 8'h07, 8'h22, 8'h90, 8'h0F};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x_valid = 1'b1; x = pre[i];
            @(negedge clk);
        end
        x_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== 29'd0) begin
            errors++;
            $display("FAIL reset_mid_track: obs=%h required=%h", obs, 29'd0);
        end
        rst = 1'b0;
        traj = '{8'h07, 8'h07};
        run_traj("after_reset", 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (obs !== 29'd0) begin
            errors++;
            $display("FAIL reset_clears_results: obs=%h required=%h", obs, 29'd0);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            int span = (t % 6 == 5) ? 256 : $urandom_range(1, 40);
            int base = $urandom_range(0, 255);
            traj = {};
            for (int i = 0; i < 300; i++) traj.push_back(8'(base + $urandom_range(0, span - 1)));
            run_traj($sformatf("random%0d", t), t % 3, 1'(t % 2));
        end
    endtask

    task automatic test_back_to_back();
        traj = '{8'hAA, 8'h55, 8'hAA};
        run_traj("b2b_a", 0, 1'b0);
        traj = '{8'h55, 8'h12, 8'h34, 8'h12};
        run_traj("b2b_b", 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fixed_point();
        test_two_cycle();
        test_transient();
        test_bubbles();
        test_worst_case();
        test_reset_mid_track();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
